// File: rtl/load_store_unit.sv
// Data-side load/store sequencer for combined_memory. Response 2+MEM_WAIT cycles after accept (1 on error);
// one request in flight: req_ready drops until the response handshake, rsp_valid holds until rsp_ready.
module load_store_unit #(
  parameter int WORD_SIZE = 32,
  parameter int MEM_WAIT  = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_store,
  input  logic [2:0]           req_funct3,
  input  logic [WORD_SIZE-1:0] req_addr,
  input  logic [WORD_SIZE-1:0] req_wdata,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [WORD_SIZE-1:0] rsp_data,
  output logic                 rsp_err,
  output logic                 mem_write_en,
  output logic [WORD_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0] mem_write_data,
  output logic [1:0]           mem_ctrl,
  input  logic [WORD_SIZE-1:0] mem_data
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t               state_q, state_d;
  logic                 store_q, store_d;
  logic [2:0]           funct3_q, funct3_d;
  logic [WORD_SIZE-1:0] addr_q, addr_d;
  logic [WORD_SIZE-1:0] wdata_q, wdata_d;
  logic [3:0]           cnt_q, cnt_d;
  logic                 req_ready_q, req_ready_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic                 rsp_err_q, rsp_err_d;
  logic [WORD_SIZE-1:0] rsp_data_q, rsp_data_d;
  logic                 mem_we_q, mem_we_d;
  logic [WORD_SIZE-1:0] mem_addr_q, mem_addr_d;
  logic [WORD_SIZE-1:0] mem_wdata_q, mem_wdata_d;
  logic [1:0]           mem_ctrl_q, mem_ctrl_d;

  logic                 req_legal;
  logic                 req_misaligned;
  logic                 req_err;
  logic [WORD_SIZE-1:0] load_ext;

  always_comb begin
    case (req_funct3)
      3'b000, 3'b001, 3'b010: req_legal = 1'b1;
      3'b100, 3'b101:         req_legal = !req_store;
      default:                req_legal = 1'b0;
    endcase
    req_misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                     ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    req_err = !req_legal || req_misaligned;
  end

  always_comb begin
    case (funct3_q)
      3'b000:  load_ext = {{(WORD_SIZE-8){mem_data[7]}}, mem_data[7:0]};
      3'b001:  load_ext = {{(WORD_SIZE-16){mem_data[15]}}, mem_data[15:0]};
      3'b100:  load_ext = {{(WORD_SIZE-8){1'b0}}, mem_data[7:0]};
      3'b101:  load_ext = {{(WORD_SIZE-16){1'b0}}, mem_data[15:0]};
      default: load_ext = mem_data;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    store_d     = store_q;
    funct3_d    = funct3_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    req_ready_d = 1'b0;
    rsp_valid_d = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    mem_ctrl_d  = '0;
    case (state_q)
      IDLE: begin
        req_ready_d = 1'b1;
        if (req_valid && req_ready_q) begin
          req_ready_d = 1'b0;
          store_d     = req_store;
          funct3_d    = req_funct3;
          addr_d      = req_addr;
          wdata_d     = req_wdata;
          rsp_data_d  = '0;
          if (req_err) begin
            state_d     = RESP;
            rsp_err_d   = 1'b1;
            rsp_valid_d = 1'b1;
          end else begin
            // Memory outputs are registered, so the first ACCESS cycle is set up here.
            state_d     = ACCESS;
            rsp_err_d   = 1'b0;
            cnt_d       = 4'(MEM_WAIT);
            mem_addr_d  = req_addr;
            mem_wdata_d = req_wdata;
            mem_ctrl_d  = req_funct3[1:0];
            mem_we_d    = req_store && (MEM_WAIT == 0);
          end
        end
      end
      ACCESS: begin
        if (cnt_q == 4'd0) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_data_d  = store_q ? '0 : load_ext;
        end else begin
          cnt_d       = cnt_q - 4'd1;
          mem_addr_d  = addr_q;
          mem_wdata_d = wdata_q;
          mem_ctrl_d  = funct3_q[1:0];
          mem_we_d    = store_q && (cnt_q == 4'd1);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          req_ready_d = 1'b1;
          rsp_data_d  = '0;
          rsp_err_d   = 1'b0;
        end else begin
          rsp_valid_d = 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      store_q     <= 1'b0;
      funct3_q    <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_ctrl_q  <= '0;
    end else begin
      state_q     <= state_d;
      store_q     <= store_d;
      funct3_q    <= funct3_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_data_q  <= rsp_data_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_ctrl_q  <= mem_ctrl_d;
    end
  end

  assign req_ready      = req_ready_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_data       = rsp_data_q;
  assign rsp_err        = rsp_err_q;
  // A reset arriving in the final store cycle must not commit the write.
  assign mem_write_en   = mem_we_q & ~rst;
  assign mem_addr       = mem_addr_q;
  assign mem_write_data = mem_wdata_q;
  assign mem_ctrl       = mem_ctrl_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: two instances (MEM_WAIT 0 and 2) each with a byte-array memory,
// checked against a byte-level reference of the load/store rules.
module tb_load_store_unit;

  logic        clk;
  logic        rst;
  logic        sel;
  logic        req_valid;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_ready;

  logic        req_ready_0, rsp_valid_0, rsp_err_0, mem_write_en_0;
  logic [31:0] rsp_data_0, mem_addr_0, mem_write_data_0, mem_data_0;
  logic [1:0]  mem_ctrl_0;
  logic        req_ready_2, rsp_valid_2, rsp_err_2, mem_write_en_2;
  logic [31:0] rsp_data_2, mem_addr_2, mem_write_data_2, mem_data_2;
  logic [1:0]  mem_ctrl_2;

  logic [7:0]  m0 [0:1023] = '{default: 8'h00};
  logic [7:0]  m2 [0:1023] = '{default: 8'h00};
  logic [7:0]  ref_mem [0:1][0:1023];

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          wc0 = 0, wc2 = 0;
  logic [1:0]  last_ctrl0, last_ctrl2;
  logic [31:0] last_addr0, last_addr2;

  logic        cur_st;
  logic [2:0]  cur_f3;
  logic [31:0] cur_a, cur_wd;
  logic        exp_err;
  logic [31:0] exp_data;
  int          exp_lat, exp_w, wbase, acc;

  load_store_unit #(.WORD_SIZE(32), .MEM_WAIT(0)) dut0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid & ~sel), .req_ready(req_ready_0), .req_store(req_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid_0), .rsp_ready(rsp_ready), .rsp_data(rsp_data_0), .rsp_err(rsp_err_0),
    .mem_write_en(mem_write_en_0), .mem_addr(mem_addr_0), .mem_write_data(mem_write_data_0),
    .mem_ctrl(mem_ctrl_0), .mem_data(mem_data_0)
  );

  load_store_unit #(.WORD_SIZE(32), .MEM_WAIT(2)) dut2 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid & sel), .req_ready(req_ready_2), .req_store(req_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid_2), .rsp_ready(rsp_ready), .rsp_data(rsp_data_2), .rsp_err(rsp_err_2),
    .mem_write_en(mem_write_en_2), .mem_addr(mem_addr_2), .mem_write_data(mem_write_data_2),
    .mem_ctrl(mem_ctrl_2), .mem_data(mem_data_2)
  );

  wire        req_ready_s    = sel ? req_ready_2 : req_ready_0;
  wire        rsp_valid_s    = sel ? rsp_valid_2 : rsp_valid_0;
  wire        rsp_err_s      = sel ? rsp_err_2 : rsp_err_0;
  wire [31:0] rsp_data_s     = sel ? rsp_data_2 : rsp_data_0;
  wire        mem_write_en_s = sel ? mem_write_en_2 : mem_write_en_0;
  wire [31:0] mem_addr_s     = sel ? mem_addr_2 : mem_addr_0;
  wire [31:0] mem_wdata_s    = sel ? mem_write_data_2 : mem_write_data_0;
  wire [1:0]  mem_ctrl_s     = sel ? mem_ctrl_2 : mem_ctrl_0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  // Little-endian byte RAMs standing in for combined_memory.
  assign mem_data_0 = {m0[mem_addr_0[9:0] + 10'd3], m0[mem_addr_0[9:0] + 10'd2],
                       m0[mem_addr_0[9:0] + 10'd1], m0[mem_addr_0[9:0]]};
  assign mem_data_2 = {m2[mem_addr_2[9:0] + 10'd3], m2[mem_addr_2[9:0] + 10'd2],
                       m2[mem_addr_2[9:0] + 10'd1], m2[mem_addr_2[9:0]]};

  always @(posedge clk) begin
    if (mem_write_en_0) begin
      for (int i = 0; i < 4; i++)
        if (i < (1 << mem_ctrl_0)) m0[mem_addr_0[9:0] + 10'(i)] = mem_write_data_0[8*i +: 8];
      wc0++;
      last_ctrl0 = mem_ctrl_0;
      last_addr0 = mem_addr_0;
    end
  end

  always @(posedge clk) begin
    if (mem_write_en_2) begin
      for (int i = 0; i < 4; i++)
        if (i < (1 << mem_ctrl_2)) m2[mem_addr_2[9:0] + 10'(i)] = mem_write_data_2[8*i +: 8];
      wc2++;
      last_ctrl2 = mem_ctrl_2;
      last_addr2 = mem_addr_2;
    end
  end

  function automatic logic model_err(input logic st, input logic [2:0] f3, input logic [31:0] a);
    int sz;
    logic legal;
    legal = st ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    if (!legal) return 1'b1;
    sz = 1 << f3[1:0];
    return (a % sz) != 0;
  endfunction

  function automatic logic [31:0] model_load(input int d, input logic [2:0] f3, input logic [31:0] a);
    int n;
    logic [31:0] v;
    n = 1 << f3[1:0];
    v = 0;
    for (int i = 0; i < n; i++)
      v = v | (32'(ref_mem[d][(int'(a[9:0]) + i) % 1024]) << (8 * i));
    if (f3 == 3'd0 && v >= 32'd128)    v = v - 32'd256;
    if (f3 == 3'd1 && v >= 32'h8000)   v = v - 32'h10000;
    return v;
  endfunction

  task automatic send_req(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    int d;
    d = sel ? 1 : 0;
    checks++;
    if (req_ready_s !== 1'b1) begin
      errors++;
      $display("FAIL req_ready_before_accept: got %b want 1", req_ready_s);
    end
    req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd; req_valid = 1'b1;
    cur_st = st; cur_f3 = f3; cur_a = a; cur_wd = wd;
    exp_err  = model_err(st, f3, a);
    exp_data = (exp_err || st) ? 32'd0 : model_load(d, f3, a);
    exp_lat  = exp_err ? 1 : 2 + (sel ? 2 : 0);
    exp_w    = (!exp_err && st) ? 1 : 0;
    wbase    = sel ? wc2 : wc0;
    @(posedge clk); #1;
    acc = cyc;
    req_valid  = 1'b0;
    req_store  = 1'($urandom);
    req_funct3 = 3'($urandom);
    req_addr   = $urandom;
    req_wdata  = $urandom;
  endtask

  task automatic wait_rsp(input int hold, input bit early);
    bit got;
    int lat;
    int d;
    got = 0;
    d = sel ? 1 : 0;
    if (early) rsp_ready = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if (rsp_valid_s === 1'b1) begin
        got = 1;
        break;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (!got) begin
      errors++;
      rsp_ready = 1'b0;
      $display("FAIL rsp_timeout: no rsp_valid within 40 cycles");
      return;
    end
    lat = cyc - acc + 1;
    checks++;
    if (lat !== exp_lat) begin
      errors++;
      $display("FAIL rsp_latency: got %0d want %0d (st=%b f3=%0d a=%h)", lat, exp_lat, cur_st, cur_f3, cur_a);
    end
    checks++;
    if (rsp_data_s !== exp_data) begin
      errors++;
      $display("FAIL rsp_data: got %h want %h (st=%b f3=%0d a=%h)", rsp_data_s, exp_data, cur_st, cur_f3, cur_a);
    end
    checks++;
    if (rsp_err_s !== exp_err) begin
      errors++;
      $display("FAIL rsp_err: got %b want %b (st=%b f3=%0d a=%h)", rsp_err_s, exp_err, cur_st, cur_f3, cur_a);
    end
    if (!early) begin
      for (int h = 0; h < hold; h++) begin
        @(posedge clk); #1;
        checks++;
        if (rsp_valid_s !== 1'b1 || rsp_data_s !== exp_data || rsp_err_s !== exp_err || req_ready_s !== 1'b0) begin
          errors++;
          $display("FAIL rsp_hold: got v=%b d=%h e=%b rdy=%b want v=1 d=%h e=%b rdy=0",
                   rsp_valid_s, rsp_data_s, rsp_err_s, req_ready_s, exp_data, exp_err);
        end
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid_s !== 1'b0 || req_ready_s !== 1'b1 || rsp_data_s !== 32'd0) begin
      errors++;
      $display("FAIL after_handshake: got v=%b rdy=%b d=%h want v=0 rdy=1 d=0", rsp_valid_s, req_ready_s, rsp_data_s);
    end
    checks++;
    if (((sel ? wc2 : wc0) - wbase) !== exp_w) begin
      errors++;
      $display("FAIL write_count: got %0d want %0d", (sel ? wc2 : wc0) - wbase, exp_w);
    end
    if (exp_w == 1) begin
      checks++;
      if ((sel ? last_ctrl2 : last_ctrl0) !== cur_f3[1:0] || (sel ? last_addr2 : last_addr0) !== cur_a) begin
        errors++;
        $display("FAIL write_ctrl_addr: got ctrl=%0d addr=%h want ctrl=%0d addr=%h",
                 sel ? last_ctrl2 : last_ctrl0, sel ? last_addr2 : last_addr0, cur_f3[1:0], cur_a);
      end
      for (int i = 0; i < (1 << cur_f3[1:0]); i++)
        ref_mem[d][(int'(cur_a[9:0]) + i) % 1024] = cur_wd[8*i +: 8];
    end
  endtask

  task automatic txn(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    send_req(st, f3, a, wd);
    wait_rsp(0, 1'b0);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    sel = 1'b0;
    checks++;
    if (req_ready_s !== 1'b1 || rsp_valid_s !== 1'b0 || rsp_err_s !== 1'b0 || rsp_data_s !== 32'd0) begin
      errors++;
      $display("FAIL reset_rsp: got rdy=%b v=%b e=%b d=%h want 1 0 0 0", req_ready_s, rsp_valid_s, rsp_err_s, rsp_data_s);
    end
    checks++;
    if (mem_write_en_s !== 1'b0 || mem_addr_s !== 32'd0 || mem_wdata_s !== 32'd0 || mem_ctrl_s !== 2'd0) begin
      errors++;
      $display("FAIL reset_mem: got we=%b a=%h wd=%h c=%0d want all 0", mem_write_en_s, mem_addr_s, mem_wdata_s, mem_ctrl_s);
    end
    sel = 1'b1;
    #1;
    checks++;
    if (req_ready_s !== 1'b1 || rsp_valid_s !== 1'b0) begin
      errors++;
      $display("FAIL reset_wait2: got rdy=%b v=%b want 1 0", req_ready_s, rsp_valid_s);
    end
    sel = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (req_ready_s !== 1'b1 || rsp_valid_s !== 1'b0 || mem_write_en_s !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: got rdy=%b v=%b we=%b want 1 0 0", req_ready_s, rsp_valid_s, mem_write_en_s);
    end
  endtask

  task automatic test_loads;
    sel = 1'b0;
    txn(1'b1, 3'd2, 32'h0, 32'h0044A303);
    txn(1'b0, 3'd0, 32'h1, 32'h0);
    txn(1'b0, 3'd4, 32'h1, 32'h0);
    txn(1'b0, 3'd1, 32'h0, 32'h0);
    txn(1'b0, 3'd2, 32'h0, 32'h0);
  endtask

  task automatic test_stores;
    sel = 1'b0;
    txn(1'b1, 3'd1, 32'h100, 32'hDEADBEEF);
    txn(1'b0, 3'd2, 32'h100, 32'h0);
    txn(1'b1, 3'd0, 32'h103, 32'h00000012);
    txn(1'b0, 3'd2, 32'h100, 32'h0);
    txn(1'b0, 3'd5, 32'h102, 32'h0);
  endtask

  task automatic test_errors;
    sel = 1'b0;
    txn(1'b0, 3'd2, 32'h102, 32'h0);
    txn(1'b1, 3'd1, 32'h101, 32'hFFFFFFFF);
    txn(1'b0, 3'd3, 32'h100, 32'h0);
    txn(1'b1, 3'd4, 32'h100, 32'hFFFFFFFF);
  endtask

  task automatic test_mem_wait;
    sel = 1'b1;
    send_req(1'b1, 3'd2, 32'h40, 32'hCAFEF00D);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (mem_addr_s !== 32'h40 || mem_ctrl_s !== 2'd2 || mem_wdata_s !== 32'hCAFEF00D ||
          mem_write_en_s !== (i == 2)) begin
        errors++;
        $display("FAIL access_cycle%0d: got a=%h c=%0d wd=%h we=%b want a=40 c=2 wd=cafef00d we=%b",
                 i, mem_addr_s, mem_ctrl_s, mem_wdata_s, mem_write_en_s, i == 2);
      end
      @(posedge clk); #1;
    end
    wait_rsp(0, 1'b0);
    txn(1'b0, 3'd2, 32'h40, 32'h0);
    txn(1'b0, 3'd0, 32'h43, 32'h0);
    sel = 1'b0;
  endtask

  task automatic test_back_to_back;
    sel = 1'b0;
    send_req(1'b0, 3'd2, 32'h0, 32'h0);
    req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'd0; req_addr = 32'h1;
    wait_rsp(5, 1'b0);
    send_req(1'b0, 3'd0, 32'h1, 32'h0);
    wait_rsp(0, 1'b0);
  endtask

  task automatic test_reset_mid;
    sel = 1'b0;
    send_req(1'b1, 3'd2, 32'h80, 32'h11223344);
    rst = 1'b1;
    #1;
    checks++;
    if (mem_write_en_s !== 1'b0) begin
      errors++;
      $display("FAIL write_during_reset: got %b want 0", mem_write_en_s);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (req_ready_s !== 1'b1 || rsp_valid_s !== 1'b0 || (wc0 - wbase) !== 0) begin
      errors++;
      $display("FAIL reset_mid_state: got rdy=%b v=%b writes=%0d want 1 0 0", req_ready_s, rsp_valid_s, wc0 - wbase);
    end
    txn(1'b0, 3'd2, 32'h80, 32'h0);
  endtask

  task automatic test_random(input logic s, input int n);
    logic st;
    logic [2:0] f3;
    sel = s;
    for (int i = 0; i < n; i++) begin
      st = 1'($urandom);
      f3 = 3'($urandom);
      send_req(st, f3, 32'($urandom_range(0, 255)), $urandom);
      wait_rsp($urandom_range(0, 3), $urandom_range(0, 3) == 0);
    end
    sel = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 1024; i++) ref_mem[d][i] = 8'h00;
    rst = 1'b1; sel = 1'b0; req_valid = 1'b0; req_store = 1'b0;
    req_funct3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0; rsp_ready = 1'b0;
    test_reset;
    test_loads;
    test_stores;
    test_errors;
    test_mem_wait;
    test_back_to_back;
    test_reset_mid;
    test_random(1'b0, 60);
    test_random(1'b1, 20);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the core's memory-stage datapath and combined_memory; owns every data-side access to that memory.
- Accepts one load/store request per valid/ready handshake and checks alignment and funct3 legality.
- Drives the memory's write_en/addr/write_data/ctrl for a parameterised number of cycles, then returns the sign/zero-extended load result or an error flag.

Parameters:
WORD_SIZE, 32, data/address width; must match combined_memory.
MEM_WAIT, 0, extra cycles the address is held before read data is sampled or the write is committed (0..15).

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous active-high reset
req_valid  input  1  request present
req_ready  output  1  unit can accept a request
req_store  input  1  1 = store, 0 = load
req_funct3  input  3  RISC-V funct3 of the load/store
req_addr  input  WORD_SIZE  effective byte address
req_wdata  input  WORD_SIZE  store data, rs2; low bytes used
rsp_valid  output  1  response present
rsp_ready  input  1  consumer accepts response
rsp_data  output  WORD_SIZE  extended load result; 0 for stores and errors
rsp_err  output  1  misaligned or illegal funct3; no memory write occurred
mem_write_en  output  1  to combined_memory write_en
mem_addr  output  WORD_SIZE  to combined_memory addr
mem_write_data  output  WORD_SIZE  to combined_memory write_data
mem_ctrl  output  2  to combined_memory ctrl (0 byte, 1 half, 2 word)
mem_data  input  WORD_SIZE  from combined_memory data (asynchronous read)

Behaviour:
- States are IDLE, ACCESS and RESP; rst forces IDLE.
- Outputs in reset and in IDLE:
  - req_ready=1; all other outputs 0.
  - mem_addr, mem_write_data and mem_ctrl are 0 outside ACCESS.
- IDLE: on req_valid & req_ready, latch store, funct3, addr and wdata.
  - Legal loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Legal stores: 000 SB, 001 SH, 010 SW.
  - Any other funct3 is illegal.
  - Misaligned: halfword with addr[0]=1, or word with addr[1:0]!=0.
  - Illegal or misaligned: go to RESP with rsp_err=1 and rsp_data=0; mem_write_en never asserts.
  - Otherwise: go to ACCESS and load wait counter = MEM_WAIT.
- ACCESS: mem_addr=latched addr, mem_ctrl=funct3[1:0], mem_write_data=latched wdata, all held stable.
  - Counter decrements each cycle.
  - The final cycle is the one where counter==0.
  - Store: mem_write_en=1 only in the final ACCESS cycle, so exactly one memory write per store.
  - Load: mem_data is sampled at the end of the final cycle and extended:
    - LB/LH sign-extend bits 7 / 15.
    - LBU/LHU zero-extend.
    - LW passes through.
  - Next state is RESP.
- RESP: rsp_valid=1; rsp_data and rsp_err held stable until rsp_ready=1, then IDLE.
  - Store responses carry rsp_data=0 and rsp_err=0.
- Latency, MEM_WAIT=0: accept at edge N; ACCESS during cycle N+1; rsp_valid from cycle N+2.
  - General case: rsp_valid arrives 2+MEM_WAIT cycles after accept.
  - Error path: rsp_valid 1 cycle after accept.
- No overlap: req_ready=0 in ACCESS and RESP.
  - A req_valid held during the RESP handshake cycle is accepted the following cycle, in IDLE.
  - Peak throughput is one access per 3+MEM_WAIT cycles.
- rsp_ready held high before rsp_valid has no effect; rsp_valid is never dropped without a handshake.
- Request inputs are ignored outside IDLE; latched values are used.
- Reset mid-operation: state returns to IDLE at the reset edge.
  - mem_write_en is gated combinationally by !rst, so no write is committed during a reset cycle.
  - A pending response is discarded.
- Address arithmetic is none: addr is passed through unmodified. Wrap at the RAM boundary is combined_memory's concern.

Test Plan:
- Preload RAM[0..3]=03 A3 44 00; LB addr 1 -> rsp_data 0xFFFFFFA3; LBU addr 1 -> 0x000000A3; LH addr 0 -> 0xFFFFA303; LW addr 0 -> 0x0044A303; each with rsp_valid exactly 2 cycles after accept.
- SH wdata 0xDEADBEEF addr 0x100 -> one-cycle mem_write_en with mem_ctrl=1; then LW 0x100 -> 0x0000BEEF; SB 0x12 addr 0x103, then LW 0x100 -> 0x1200BEEF.
- LW addr 0x102, SH addr 0x101, funct3 011 load, SB with funct3 100 -> each gives rsp_err=1, rsp_data=0, rsp_valid 1 cycle after accept, mem_write_en never high.
- MEM_WAIT=2: SW 0xCAFEF00D addr 0x40 -> mem_addr stable for 3 ACCESS cycles, mem_write_en only in the third; LW 0x40 response 4 cycles after accept = 0xCAFEF00D.
- Backpressure: hold rsp_ready=0 for 5 cycles -> rsp_valid and rsp_data stable, req_ready=0; a request waiting with req_valid=1 is accepted the cycle after the handshake.
- Assert rst during the final ACCESS cycle of SW 0x11223344 addr 0x80 -> mem_write_en=0 that cycle, next cycle IDLE with req_ready=1 and rsp_valid=0; subsequent LW 0x80 returns 0.
